// File: rtl/tone_gen.sv
// tone_gen: 50%-duty square-wave tone from a 4-bit note code.
// Pitch changes and release only take effect at full-period boundaries.
module tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIV_W  = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note,
    output logic       aud_pwm,
    output logic       aud_sd,
    output logic [3:0] cur_note,
    output logic       period_start
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    function automatic logic [63:0] fchz(input int n);
        logic [63:0] f;
        case (n)
            1:       f = 64'd26163;
            2:       f = 64'd29366;
            3:       f = 64'd32963;
            4:       f = 64'd34923;
            5:       f = 64'd39200;
            6:       f = 64'd44000;
            7:       f = 64'd49388;
            8:       f = 64'd52325;
            default: f = 64'd0;
        endcase
        return f;
    endfunction

    // Table holds HALF-1 so a reload lands directly in the down-counter.
    logic [DIV_W-1:0] half_m1 [16];

    for (genvar i = 0; i < 16; i++) begin : g_half
        localparam logic [63:0] F   = fchz(i);
        localparam logic [63:0] H64 =
            (F != 64'd0) ? (64'(CLK_HZ) * 64'd50) / F : 64'd1;
        assign half_m1[i] = DIV_W'(H64 - 64'd1);
    end

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic             pwm, pwm_nxt;
    logic [3:0]       cur, cur_nxt;
    logic             ps, ps_nxt;
    logic             note_ok;

    assign note_ok = (note != 4'd0) && (note <= 4'd8);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            pwm   <= 1'b0;
            cur   <= 4'd0;
            ps    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pwm   <= pwm_nxt;
            cur   <= cur_nxt;
            ps    <= ps_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pwm_nxt   = pwm;
        cur_nxt   = cur;
        ps_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (note_ok) begin
                    state_nxt = PLAY;
                    cur_nxt   = note;
                    cnt_nxt   = half_m1[note];
                    pwm_nxt   = 1'b1;
                    ps_nxt    = 1'b1;
                end
            end
            PLAY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (pwm) begin
                    // Low half keeps the sounding pitch regardless of note.
                    pwm_nxt = 1'b0;
                    cnt_nxt = half_m1[cur];
                end else if (note_ok) begin
                    cur_nxt = note;
                    cnt_nxt = half_m1[note];
                    pwm_nxt = 1'b1;
                    ps_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pwm_nxt   = 1'b0;
                    cur_nxt   = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        aud_pwm      = pwm;
        aud_sd       = (state == PLAY);
        cur_note     = cur;
        period_start = ps;
    end

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator sitting directly downstream of the switch-to-note encoder. It consumes the registered 4-bit note code and drives the board's mono audio amplifier with a 50%-duty square wave at the selected pitch. Pitch changes and note release take effect only at full-period boundaries, so there are no runt pulses or clicks.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz; sets the half-period table.
- DIV_W, 18: half-period counter width; must hold the largest table entry.
- CLK  input  1  system clock.
- RESET  input  1  reset; asynchronous, active-high.
- note  input  4  note code: 0 none, 1 C4, 2 D, 3 E, 4 F, 5 G, 6 A, 7 B, 8 C5; codes 9–15 are treated as none. The input is registered upstream; no resynchronisation here.
- aud_pwm  output  1  square-wave audio out.
- aud_sd  output  1  amplifier enable; 1 while in PLAY.
- cur_note  output  4  code currently sounding; 0 when idle.
- period_start  output  1  one-cycle pulse on each rising edge of aud_pwm.

## Operation
- Half-period table, computed at elaboration: HALF[n] = CLK_HZ*50 / f_cHz[n], integer truncation, with f in centihertz (26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325).
- At 100 MHz, HALF = 191109, 170264, 151685, 143172, 127551, 113636, 101239, 95556.
- Arithmetic:
  - Use 64-bit intermediates during elaboration.
  - cnt is DIV_W bits, unsigned.
- FSM states:
  - IDLE: aud_pwm=0, aud_sd=0, cur_note=0, cnt=0.
  - PLAY: tone active.
- IDLE → PLAY, when note is valid (1–8) at a clock edge. On that same edge:
  - cur_note<=note; cnt<=HALF[note]-1; aud_pwm<=1; aud_sd<=1; period_start<=1.
- PLAY, cnt≠0: cnt<=cnt-1. No other change.
- PLAY, cnt=0 and aud_pwm=1 (end of high half):
  - aud_pwm<=0; cnt<=HALF[cur_note]-1.
  - The low half always uses the current note, even if note has changed.
- PLAY, cnt=0 and aud_pwm=0 (end of period):
  - If note is valid: cur_note<=note; cnt<=HALF[note]-1; aud_pwm<=1; period_start<=1.
  - Otherwise go to IDLE: aud_pwm<=0, aud_sd<=0, cur_note<=0, cnt<=0.
- A change of note mid-period is ignored until the period boundary. Only the value present at the boundary edge matters; intermediate values are never latched.
- Returning to a valid note within the same period sustains the tone with no gap.
- period_start is 0 on every cycle not listed above.

## Timing
- Reset values: aud_pwm=0, aud_sd=0, cur_note=0, period_start=0, cnt=0, state IDLE.
- Reset is asynchronous and takes effect mid-period with no completion of the current half.
- Start latency: note becomes valid before edge k → aud_pwm=1 and aud_sd=1 after edge k (1 cycle).
- High half lasts exactly HALF[n] cycles; low half lasts exactly HALF[n] cycles. Period is 2·HALF[n], duty exactly 50%.
- Release latency: the tone stops at the first period end after note becomes invalid; worst case 2·HALF[n] cycles.
- aud_pwm never has a high or low phase shorter than HALF of the sounding note.
- Boundary cases:
  - Note valid at the same edge as the end of a period: the new note's high half starts on that edge, with no idle cycle.
  - Code 9–15 at a period end: treated as release.
  - Code 9–15 in IDLE: stays in IDLE.

## Test plan
- Reset, then note=6 (A): aud_pwm high 1 cycle later. Measure 113636 cycles high, then 113636 low, period_start pulsing every 227272 cycles; aud_sd=1, cur_note=6.
- Note 1 playing; switch to note 8 at cycle 50000 of the high half: remainder of that C4 period unchanged (191109 high, 191109 low), then C5 periods of 95556+95556; cur_note changes exactly at the boundary edge.
- Note 3 playing; set note=0 mid-low-half: E period completes, then aud_pwm=0, aud_sd=0, cur_note=0 in IDLE; no further period_start.
- Glitch: note 5 → 0 → 5 within one period: tone continues with no gap and no period_start skipped.
- Assert RESET asynchronously mid-high-half, between clock edges: aud_pwm, aud_sd, cur_note, period_start all 0 immediately. Release with note=2: restart 1 cycle after the first edge.
- Note=12 from IDLE: no output. Note=12 during PLAY: release at period end.
